// File: rtl/serializer_sched.sv
// Round-robin scheduler feeding one INWIDTH->OUTWIDTH serializer; first beat the cycle after accept.
// Output is valid/ready: beats hold stable under backpressure, requesters wait in IDLE until granted.
module serializer_sched #(
  parameter  int NREQ     = 4,
  parameter  int INWIDTH  = 256,
  parameter  int OUTWIDTH = 8,
  localparam int MAXB     = INWIDTH / OUTWIDTH,
  localparam int LW       = $clog2(MAXB) + 1,
  localparam int SW       = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*INWIDTH-1:0] req_data,
  input  logic [NREQ*LW-1:0]      req_length,
  output logic [OUTWIDTH-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [SW-1:0]           out_src,
  output logic                    busy
);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [SW-1:0]        rr_ptr;
  logic [INWIDTH-1:0]   shift_reg;
  logic [LW-1:0]        cnt;

  logic [INWIDTH-1:0]   data_arr [NREQ];
  logic [LW-1:0]        len_arr  [NREQ];
  logic [SW-1:0]        winner;
  logic [SW-1:0]        idx_w;
  logic                 found;
  logic [LW-1:0]        win_len;
  logic [LW-1:0]        clamped;
  logic                 accept;
  logic                 fire;
  int                   idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*INWIDTH +: INWIDTH];
      len_arr[i]  = req_length[i*LW +: LW];
    end
  end

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = SW'(idx);
      if (!found && req_valid[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign win_len = len_arr[winner];
  assign clamped = (win_len > LW'(MAXB)) ? LW'(MAXB) : win_len;
  assign accept  = (state == IDLE) && found;
  assign fire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (found && reset) req_ready[winner] = 1'b1;
        if (accept && clamped != '0) state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = shift_reg[OUTWIDTH-1:0];
        out_last  = (cnt == LW'(1));
        if (fire && cnt == LW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      out_src   <= '0;
    end else if (accept) begin
      rr_ptr    <= (winner == SW'(NREQ-1)) ? '0 : winner + SW'(1);
      shift_reg <= data_arr[winner];
      cnt       <= clamped;
      out_src   <= winner;
    end else if (fire) begin
      shift_reg <= shift_reg >> OUTWIDTH;
      cnt       <= cnt - LW'(1);
    end
  end

endmodule

// File: tb/tb_serializer_sched.sv
// Directed bench for serializer_sched: vector table of single-requester blocks plus multi-cycle sequences.
module tb_serializer_sched;
  localparam int NREQ = 4;
  localparam int IW   = 256;
  localparam int OW   = 8;
  localparam int LW   = 6;
  localparam int SW   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*IW-1:0] req_data;
  logic [NREQ*LW-1:0] req_length;
  logic [OW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [SW-1:0]      out_src;
  logic               busy;

  always #5 clk = ~clk;

  serializer_sched #(.NREQ(NREQ), .INWIDTH(IW), .OUTWIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_length(req_length),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_src(out_src), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int              src;
    logic [LW-1:0]   len;
    logic [IW-1:0]   data;
    int              beats;
    logic [7:0]      first_b;
    logic [7:0]      last_b;
    logic [NREQ-1:0] grant;
    logic [SW-1:0]   rr_after;
  } vec_t;

  vec_t vecs [6];

  // Called at the sample point of the first cycle after accept; returns at the following idle sample point.
  task automatic collect(input int n, input logic [IW-1:0] d, input int src,
                         output logic [7:0] f, output logic [7:0] l);
    f = 8'h00;
    l = 8'h00;
    for (int k = 0; k < n; k++) begin
      chk("beat_valid", 64'(out_valid), 64'd1);
      chk("beat_data", 64'(out_data), 64'(d[k*8 +: 8]));
      chk("beat_last", 64'(out_last), 64'(k == n - 1));
      chk("beat_src", 64'(out_src), 64'(src));
      chk("beat_busy", 64'(busy), 64'd1);
      if (k == 0) f = out_data;
      l = out_data;
      @(negedge clk); #1;
    end
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_data", 64'(out_data), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  logic [IW-1:0] ramp;
  logic [IW-1:0] pat8;
  logic [IW-1:0] blk_b;
  logic [7:0]    f_b, l_b;
  logic          rdy_seq [5];
  logic [7:0]    exp_dat [5];
  logic          exp_lst [5];
  int            hs;

  initial begin
    ramp  = 256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201;
    pat8  = 256'h0807060504030201;
    blk_b = ~ramp;
    vecs[0] = '{0, 6'd4,  256'h44332211,                 4,  8'h11, 8'h44, 4'b0001, 2'd1};
    vecs[1] = '{1, 6'd0,  256'hdeadbeef,                 0,  8'h00, 8'h00, 4'b0010, 2'd2};
    vecs[2] = '{2, 6'd40, ramp,                          32, 8'h01, 8'h20, 4'b0100, 2'd3};
    vecs[3] = '{3, 6'd32, {8'hA5, 240'd0, 8'h5A},        32, 8'h5A, 8'hA5, 4'b1000, 2'd0};
    vecs[4] = '{1, 6'd1,  256'h77,                       1,  8'h77, 8'h77, 4'b0010, 2'd2};
    vecs[5] = '{0, 6'd63, ramp,                          32, 8'h01, 8'h20, 4'b0001, 2'd1};
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_dat = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC};
    exp_lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state, with all requesters asserting to show req_ready is forced low.
    reset      = 1'b0;
    req_valid  = '1;
    req_data   = '0;
    req_length = '0;
    out_ready  = 1'b1;
    #12;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rr", 64'(dut.rr_ptr), 64'd0);
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    #1;

    // Vector table: one requester per block, sink always ready.
    for (int i = 0; i < 6; i++) begin
      req_valid = NREQ'(1) << vecs[i].src;
      req_length[vecs[i].src*LW +: LW] = vecs[i].len;
      req_data[vecs[i].src*IW +: IW]   = vecs[i].data;
      #1;
      chk("vec_grant", 64'(req_ready), 64'(vecs[i].grant));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("vec_rr", 64'(dut.rr_ptr), 64'(vecs[i].rr_after));
      collect(vecs[i].beats, vecs[i].data, vecs[i].src, f_b, l_b);
      if (vecs[i].beats > 0) begin
        chk("vec_first", 64'(f_b), 64'(vecs[i].first_b));
        chk("vec_last", 64'(l_b), 64'(vecs[i].last_b));
      end
    end

    // Backpressure: BB must hold through two stalled cycles.
    req_valid = 4'b1000;
    req_length[3*LW +: LW] = 6'd3;
    req_data[3*IW +: IW]   = 256'hCCBBAA;
    #1;
    chk("bp_grant", 64'(req_ready), 64'b1000);
    @(negedge clk);
    req_valid = '0;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      out_ready = rdy_seq[c];
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'(exp_dat[c]));
      chk("bp_last", 64'(out_last), 64'(exp_lst[c]));
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_idle", 64'(out_valid), 64'd0);
    chk("bp_handshakes", 64'(hs), 64'd3);

    // Reset mid-block after two handshakes; block is dropped, next request restarts at beat 0.
    req_valid = 4'b0100;
    req_length[2*LW +: LW] = 6'd8;
    req_data[2*IW +: IW]   = pat8;
    #1;
    chk("rs_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    #1;
    chk("rs_b0", 64'(out_data), 64'h01);
    @(negedge clk); #1;
    chk("rs_b1", 64'(out_data), 64'h02);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_rr", 64'(dut.rr_ptr), 64'd0);
    chk("rs_data", 64'(out_data), 64'd0);
    chk("rs_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rs_regrant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    collect(8, pat8, 2, f_b, l_b);
    chk("rs_first", 64'(f_b), 64'h01);
    chk("rs_lastb", 64'(l_b), 64'h08);

    // Round robin with all requesters held valid, length 1 each.
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_length[i*LW +: LW] = 6'd1;
      req_data[i*IW +: IW]   = IW'(8'h10 + i);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'(NREQ'(1) << i));
      @(negedge clk); #1;
      chk("rr_src", 64'(out_src), 64'(i));
      chk("rr_data", 64'(out_data), 64'(8'h10 + i));
      chk("rr_last", 64'(out_last), 64'd1);
      @(negedge clk);
    end
    #1;
    chk("rr_wrap", 64'(dut.rr_ptr), 64'd0);
    req_valid = 4'b0101;
    #1;
    chk("rr_after3", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rr_after3_src", 64'(out_src), 64'd0);
    @(negedge clk); #1;
    chk("rr_after3_idle", 64'(out_valid), 64'd0);

    // Two back-to-back 32-beat blocks from req1, valid held; new data loaded mid-stream is ignored.
    req_valid = 4'b0010;
    req_length[1*LW +: LW] = 6'd32;
    req_data[1*IW +: IW]   = ramp;
    #1;
    chk("b2b_grant0", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_data[1*IW +: IW] = blk_b;
    #1;
    chk("b2b_ready_stream", 64'(req_ready), 64'd0);
    collect(32, ramp, 1, f_b, l_b);
    chk("b2b_grant1", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    collect(32, blk_b, 1, f_b, l_b);
    chk("b2b_lastb", 64'(l_b), 64'h20 ^ 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
